// File: rtl/split_bus_arbiter.sv
// Two-master / three-slave bus arbiter with split-transaction parking and watchdog.
// Grants, mux selects and status flags are all registered.
module split_bus_arbiter #(
    parameter int SLAVE_LEN   = 2,
    parameter int TIMEOUT     = 256,
    parameter int ROUND_ROBIN = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 m1_request,
    input  logic                 m2_request,
    input  logic [SLAVE_LEN-1:0] m1_slave_sel,
    input  logic [SLAVE_LEN-1:0] m2_slave_sel,
    input  logic                 trans_done,
    input  logic [2:0]           split_req,
    input  logic [2:0]           split_ready,
    output logic                 m1_grant,
    output logic                 m2_grant,
    output logic                 arbiter_busy,
    output logic                 bus_busy,
    output logic                 master_sel,
    output logic [SLAVE_LEN-1:0] slave_sel,
    output logic                 split_active,
    output logic                 timeout_err
);

    localparam int WD_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [SLAVE_LEN-1:0] MAX_SLAVE = SLAVE_LEN'(2);
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        OWNED   = 2'd1,
        RELEASE = 2'd2
    } state_t;

    state_t state, state_nx;

    logic                 prio;
    logic                 split_master;
    logic [SLAVE_LEN-1:0] split_slave;
    logic [WD_W-1:0]      wd;

    logic m1_ok, m2_ok, resume;
    logic grant_go, pick_m2, split_hit, to_hit;

    logic                 own_nx;
    logic                 sel_nx;
    logic [SLAVE_LEN-1:0] slave_nx;

    // A parked split blocks its master and its slave until resumed.
    assign resume = split_active && split_ready[split_slave];
    assign m1_ok  = m1_request && (m1_slave_sel <= MAX_SLAVE) &&
                    !(split_active && (!split_master || m1_slave_sel == split_slave));
    assign m2_ok  = m2_request && (m2_slave_sel <= MAX_SLAVE) &&
                    !(split_active && (split_master || m2_slave_sel == split_slave));

    always_ff @(posedge clk) begin
        if (reset)
            state <= IDLE;
        else
            state <= state_nx;
    end

    always_comb begin
        state_nx  = state;
        grant_go  = 1'b0;
        pick_m2   = 1'b0;
        split_hit = 1'b0;
        to_hit    = 1'b0;
        case (state)
            IDLE: begin
                if (resume) begin
                    grant_go = 1'b1;
                    pick_m2  = split_master;
                end else if (m1_ok || m2_ok) begin
                    grant_go = 1'b1;
                    pick_m2  = m2_ok && (!m1_ok || (ROUND_ROBIN != 0 && prio));
                end
                if (grant_go)
                    state_nx = OWNED;
            end
            OWNED: begin
                if (trans_done) begin
                    state_nx = RELEASE;
                end else if (split_req[slave_sel]) begin
                    split_hit = 1'b1;
                    state_nx  = RELEASE;
                end else if (wd == WD_LAST) begin
                    to_hit   = 1'b1;
                    state_nx = RELEASE;
                end
            end
            RELEASE: state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        own_nx   = (state_nx == OWNED);
        sel_nx   = master_sel;
        slave_nx = slave_sel;
        if (grant_go) begin
            sel_nx = pick_m2;
            if (resume)
                slave_nx = split_slave;
            else if (pick_m2)
                slave_nx = m2_slave_sel;
            else
                slave_nx = m1_slave_sel;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            m1_grant     <= 1'b0;
            m2_grant     <= 1'b0;
            arbiter_busy <= 1'b0;
            bus_busy     <= 1'b0;
            master_sel   <= 1'b0;
            slave_sel    <= '0;
            split_active <= 1'b0;
            timeout_err  <= 1'b0;
            split_master <= 1'b0;
            split_slave  <= '0;
            prio         <= 1'b0;
            wd           <= '0;
        end else begin
            m1_grant     <= own_nx && !sel_nx;
            m2_grant     <= own_nx && sel_nx;
            arbiter_busy <= own_nx;
            bus_busy     <= own_nx;
            master_sel   <= sel_nx;
            slave_sel    <= slave_nx;
            timeout_err  <= to_hit;
            if (state == OWNED && state_nx == OWNED)
                wd <= wd + 1'b1;
            else
                wd <= '0;
            if (state == RELEASE)
                prio <= !master_sel;
            if (split_hit) begin
                split_active <= 1'b1;
                split_master <= master_sel;
                split_slave  <= slave_sel;
            end else if (state == IDLE && resume) begin
                split_active <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_split_bus_arbiter.sv
// Directed bench for split_bus_arbiter: vector table plus round-robin and
// watchdog sequences on a round-robin and a fixed-priority instance.
module tb_split_bus_arbiter;

    logic       clk = 1'b0;
    logic       reset;
    logic       m1_request, m2_request;
    logic [1:0] m1_slave_sel, m2_slave_sel;
    logic       trans_done;
    logic [2:0] split_req, split_ready;

    logic       a_g1, a_g2, a_ab, a_bb, a_ms, a_sa, a_te;
    logic [1:0] a_ss;
    logic       b_g1, b_g2, b_ab, b_bb, b_ms, b_sa, b_te;
    logic [1:0] b_ss;
    logic [8:0] out_a, out_b;

    int checks = 0;
    int fails  = 0;

    always #5 clk = ~clk;

    split_bus_arbiter #(.SLAVE_LEN(2), .TIMEOUT(8), .ROUND_ROBIN(1)) dut_a (
        .clk(clk), .reset(reset),
        .m1_request(m1_request), .m2_request(m2_request),
        .m1_slave_sel(m1_slave_sel), .m2_slave_sel(m2_slave_sel),
        .trans_done(trans_done), .split_req(split_req), .split_ready(split_ready),
        .m1_grant(a_g1), .m2_grant(a_g2), .arbiter_busy(a_ab), .bus_busy(a_bb),
        .master_sel(a_ms), .slave_sel(a_ss), .split_active(a_sa), .timeout_err(a_te)
    );

    split_bus_arbiter #(.SLAVE_LEN(2), .TIMEOUT(8), .ROUND_ROBIN(0)) dut_b (
        .clk(clk), .reset(reset),
        .m1_request(m1_request), .m2_request(m2_request),
        .m1_slave_sel(m1_slave_sel), .m2_slave_sel(m2_slave_sel),
        .trans_done(trans_done), .split_req(split_req), .split_ready(split_ready),
        .m1_grant(b_g1), .m2_grant(b_g2), .arbiter_busy(b_ab), .bus_busy(b_bb),
        .master_sel(b_ms), .slave_sel(b_ss), .split_active(b_sa), .timeout_err(b_te)
    );

    // {m1_grant, m2_grant, arbiter_busy, bus_busy, master_sel, slave_sel, split_active, timeout_err}
    assign out_a = {a_g1, a_g2, a_ab, a_bb, a_ms, a_ss, a_sa, a_te};
    assign out_b = {b_g1, b_g2, b_ab, b_bb, b_ms, b_ss, b_sa, b_te};

    typedef struct {
        logic       rst;
        logic       r1;
        logic [1:0] s1;
        logic       r2;
        logic [1:0] s2;
        logic       done;
        logic [2:0] sreq;
        logic [2:0] srdy;
        logic [8:0] exp;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic rst, input logic r1, input logic [1:0] s1,
                       input logic r2, input logic [1:0] s2, input logic done,
                       input logic [2:0] sreq, input logic [2:0] srdy,
                       input logic [8:0] exp);
        vec_t v;
        v.rst = rst; v.r1 = r1; v.s1 = s1; v.r2 = r2; v.s2 = s2;
        v.done = done; v.sreq = sreq; v.srdy = srdy; v.exp = exp;
        vecs.push_back(v);
    endtask

    task automatic drive(input logic rst, input logic r1, input logic [1:0] s1,
                         input logic r2, input logic [1:0] s2, input logic done,
                         input logic [2:0] sreq, input logic [2:0] srdy);
        reset = rst; m1_request = r1; m1_slave_sel = s1;
        m2_request = r2; m2_slave_sel = s2; trans_done = done;
        split_req = sreq; split_ready = srdy;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [8:0] act, input logic [8:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
        if ((a_g1 & a_g2) | (b_g1 & b_g2)) begin
            fails++;
            $display("FAIL %s: both grants high", name);
        end
    endtask

    initial begin
        drive(1, 0, 0, 0, 0, 0, 0, 0);

        // reset, single M1 transfer to slave 1
        add(1, 0,0, 0,0, 0, 3'b000, 3'b000, 9'b0_0_0_0_0_00_0_0);
        add(0, 1,1, 0,0, 0, 3'b000, 3'b000, 9'b1_0_1_1_0_01_0_0);
        add(0, 0,0, 0,0, 0, 3'b000, 3'b000, 9'b1_0_1_1_0_01_0_0);
        add(0, 0,0, 0,0, 1, 3'b000, 3'b000, 9'b0_0_0_0_0_01_0_0);
        add(0, 0,0, 0,0, 0, 3'b000, 3'b000, 9'b0_0_0_0_0_01_0_0);
        // tie from reset: M1 first, then M2 to slave 2 after 2-cycle gap
        add(1, 0,0, 0,0, 0, 3'b000, 3'b000, 9'b0_0_0_0_0_00_0_0);
        add(0, 1,0, 1,2, 0, 3'b000, 3'b000, 9'b1_0_1_1_0_00_0_0);
        add(0, 0,0, 1,2, 0, 3'b000, 3'b000, 9'b1_0_1_1_0_00_0_0);
        add(0, 0,0, 1,2, 1, 3'b000, 3'b000, 9'b0_0_0_0_0_00_0_0);
        add(0, 0,0, 1,2, 0, 3'b000, 3'b000, 9'b0_0_0_0_0_00_0_0);
        add(0, 0,0, 1,2, 0, 3'b000, 3'b000, 9'b0_1_1_1_1_10_0_0);
        add(0, 0,0, 0,0, 1, 3'b000, 3'b000, 9'b0_0_0_0_1_10_0_0);
        add(0, 0,0, 0,0, 0, 3'b000, 3'b000, 9'b0_0_0_0_1_10_0_0);
        // split park, other traffic, blocked requests, resume
        add(1, 0,0, 0,0, 0, 3'b000, 3'b000, 9'b0_0_0_0_0_00_0_0);
        add(0, 1,0, 0,0, 0, 3'b000, 3'b000, 9'b1_0_1_1_0_00_0_0);
        add(0, 0,0, 0,0, 0, 3'b001, 3'b000, 9'b0_0_0_0_0_00_1_0);
        add(0, 0,0, 1,1, 0, 3'b000, 3'b000, 9'b0_0_0_0_0_00_1_0);
        add(0, 0,0, 1,1, 0, 3'b000, 3'b000, 9'b0_1_1_1_1_01_1_0);
        add(0, 0,0, 0,0, 1, 3'b000, 3'b000, 9'b0_0_0_0_1_01_1_0);
        add(0, 1,2, 1,0, 0, 3'b000, 3'b000, 9'b0_0_0_0_1_01_1_0);
        add(0, 1,2, 1,0, 0, 3'b000, 3'b000, 9'b0_0_0_0_1_01_1_0);
        add(0, 0,0, 1,0, 0, 3'b000, 3'b001, 9'b1_0_1_1_0_00_0_0);
        add(0, 0,0, 0,0, 1, 3'b000, 3'b000, 9'b0_0_0_0_0_00_0_0);
        // non-selected split ignored; trans_done beats split_req
        add(1, 0,0, 0,0, 0, 3'b000, 3'b000, 9'b0_0_0_0_0_00_0_0);
        add(0, 1,2, 0,0, 0, 3'b000, 3'b000, 9'b1_0_1_1_0_10_0_0);
        add(0, 0,0, 0,0, 0, 3'b001, 3'b000, 9'b1_0_1_1_0_10_0_0);
        add(0, 0,0, 0,0, 1, 3'b100, 3'b000, 9'b0_0_0_0_0_10_0_0);
        add(0, 0,0, 0,0, 0, 3'b000, 3'b000, 9'b0_0_0_0_0_10_0_0);
        // reset mid-OWNED with split parked; invalid slave never granted
        add(1, 0,0, 0,0, 0, 3'b000, 3'b000, 9'b0_0_0_0_0_00_0_0);
        add(0, 1,0, 0,0, 0, 3'b000, 3'b000, 9'b1_0_1_1_0_00_0_0);
        add(0, 0,0, 0,0, 0, 3'b001, 3'b000, 9'b0_0_0_0_0_00_1_0);
        add(0, 0,0, 1,1, 0, 3'b000, 3'b000, 9'b0_0_0_0_0_00_1_0);
        add(0, 0,0, 1,1, 0, 3'b000, 3'b000, 9'b0_1_1_1_1_01_1_0);
        add(1, 0,0, 1,1, 0, 3'b000, 3'b000, 9'b0_0_0_0_0_00_0_0);
        add(0, 1,3, 0,0, 0, 3'b000, 3'b001, 9'b0_0_0_0_0_00_0_0);
        add(0, 1,3, 0,0, 0, 3'b000, 3'b001, 9'b0_0_0_0_0_00_0_0);
        add(0, 1,3, 0,0, 0, 3'b000, 3'b000, 9'b0_0_0_0_0_00_0_0);
        add(0, 0,0, 0,0, 0, 3'b000, 3'b000, 9'b0_0_0_0_0_00_0_0);

        foreach (vecs[i]) begin
            drive(vecs[i].rst, vecs[i].r1, vecs[i].s1, vecs[i].r2, vecs[i].s2,
                  vecs[i].done, vecs[i].sreq, vecs[i].srdy);
            step();
            chk($sformatf("vec%0d", i), out_a, vecs[i].exp);
        end

        // round robin vs fixed priority with both masters re-requesting
        drive(1, 0, 0, 0, 0, 0, 0, 0);
        step();
        chk("rr_reset_b", out_b, 9'b0_0_0_0_0_00_0_0);
        drive(0, 1, 0, 1, 2, 0, 0, 0);
        step();
        chk("rr_first_a", out_a, 9'b1_0_1_1_0_00_0_0);
        chk("rr_first_b", out_b, 9'b1_0_1_1_0_00_0_0);
        trans_done = 1'b1;
        step();
        trans_done = 1'b0;
        chk("rr_rel_a", out_a, 9'b0_0_0_0_0_00_0_0);
        step();
        chk("rr_idle_b", out_b, 9'b0_0_0_0_0_00_0_0);
        step();
        chk("rr_second_a", out_a, 9'b0_1_1_1_1_10_0_0);
        chk("fixed_second_b", out_b, 9'b1_0_1_1_0_00_0_0);

        // watchdog: M2 holds bus without trans_done
        drive(1, 0, 0, 0, 0, 0, 0, 0);
        step();
        drive(0, 0, 0, 1, 1, 0, 0, 0);
        step();
        chk("wd_grant", out_a, 9'b0_1_1_1_1_01_0_0);
        drive(0, 1, 0, 0, 0, 0, 0, 0);
        for (int i = 1; i < 8; i++) begin
            step();
            chk($sformatf("wd_hold%0d", i), out_a, 9'b0_1_1_1_1_01_0_0);
        end
        step();
        chk("wd_pulse", out_a, 9'b0_0_0_0_1_01_0_1);
        step();
        chk("wd_after", out_a, 9'b0_0_0_0_1_01_0_0);
        step();
        chk("wd_m1_grant", out_a, 9'b1_0_1_1_0_00_0_0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
